// File: rtl/riscv_core_reorder_buffer.sv
// 32-entry circular reorder buffer: dual in-order allocation, dual writeback fill,
// dual in-order commit and two combinational bypass read ports.
module riscv_core_reorder_buffer (
   input  logic        clk,
   input  logic        reset,
   input  logic        alloc0_req,
   input  logic        alloc1_req,
   input  logic        alloc0_wen,
   input  logic        alloc1_wen,
   input  logic [4:0]  alloc0_waddr,
   input  logic [4:0]  alloc1_waddr,
   output logic [4:0]  alloc0_slot,
   output logic [4:0]  alloc1_slot,
   output logic        rob_full_stall,
   input  logic        fillA_val,
   input  logic        fillB_val,
   input  logic [4:0]  fillA_slot,
   input  logic [4:0]  fillB_slot,
   input  logic [31:0] fillA_data,
   input  logic [31:0] fillB_data,
   output logic        rob_commit_val_1,
   output logic        rob_commit_val_2,
   output logic [4:0]  rob_commit_slot_1,
   output logic [4:0]  rob_commit_slot_2,
   output logic        rob_commit_wen_1,
   output logic        rob_commit_wen_2,
   output logic [4:0]  rob_commit_waddr_1,
   output logic [4:0]  rob_commit_waddr_2,
   output logic [31:0] rob_commit_data_1,
   output logic [31:0] rob_commit_data_2,
   input  logic [4:0]  rob_rd_slot_0,
   input  logic [4:0]  rob_rd_slot_1,
   output logic [31:0] rob_rd_data_0,
   output logic [31:0] rob_rd_data_1
);

   localparam int DEPTH = 32;

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] pending;
   logic             wen_mem   [DEPTH];
   logic [4:0]       waddr_mem [DEPTH];
   logic [31:0]      data_mem  [DEPTH];

   logic [4:0] head;
   logic [4:0] tail;
   logic [5:0] count;
   logic [4:0] head_plus1;
   logic       accept0;
   logic       accept1;
   logic [1:0] num_alloc;
   logic [1:0] num_commit;
   logic       fill_a_hit;
   logic       fill_b_hit;

   assign rob_full_stall = (count > 6'd30);
   assign accept0        = alloc0_req && !rob_full_stall;
   assign accept1        = alloc1_req && !rob_full_stall;
   assign alloc0_slot    = tail;
   assign alloc1_slot    = alloc0_req ? tail + 5'd1 : tail;

   assign head_plus1       = head + 5'd1;
   assign rob_commit_val_1 = valid[head] && !pending[head];
   assign rob_commit_val_2 = rob_commit_val_1 && valid[head_plus1] && !pending[head_plus1];

   assign rob_commit_slot_1  = rob_commit_val_1 ? head               : 5'd0;
   assign rob_commit_wen_1   = rob_commit_val_1 ? wen_mem[head]      : 1'b0;
   assign rob_commit_waddr_1 = rob_commit_val_1 ? waddr_mem[head]    : 5'd0;
   assign rob_commit_data_1  = rob_commit_val_1 ? data_mem[head]     : 32'd0;
   assign rob_commit_slot_2  = rob_commit_val_2 ? head_plus1           : 5'd0;
   assign rob_commit_wen_2   = rob_commit_val_2 ? wen_mem[head_plus1]   : 1'b0;
   assign rob_commit_waddr_2 = rob_commit_val_2 ? waddr_mem[head_plus1] : 5'd0;
   assign rob_commit_data_2  = rob_commit_val_2 ? data_mem[head_plus1]  : 32'd0;

   assign rob_rd_data_0 = data_mem[rob_rd_slot_0];
   assign rob_rd_data_1 = data_mem[rob_rd_slot_1];

   assign num_alloc  = {1'b0, accept0} + {1'b0, accept1};
   assign num_commit = {1'b0, rob_commit_val_1} + {1'b0, rob_commit_val_2};

   // Fills only land on live entries; a stale slot number from a flushed op is dropped.
   assign fill_a_hit = fillA_val && valid[fillA_slot];
   assign fill_b_hit = fillB_val && valid[fillB_slot];

   // NOTE: all state uses non-blocking assignments so every read in this block sees
   // the pre-edge values, letting fill, commit and alloc be written independently.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= 5'd0;
         tail    <= 5'd0;
         count   <= 6'd0;
         valid   <= '0;
         pending <= '0;
      end else begin
         if (fill_b_hit) pending[fillB_slot] <= 1'b0;
         if (fill_a_hit) pending[fillA_slot] <= 1'b0;
         if (rob_commit_val_1) valid[head]       <= 1'b0;
         if (rob_commit_val_2) valid[head_plus1] <= 1'b0;
         if (accept0) begin
            valid[alloc0_slot]   <= 1'b1;
            pending[alloc0_slot] <= 1'b1;
         end
         if (accept1) begin
            valid[alloc1_slot]   <= 1'b1;
            pending[alloc1_slot] <= 1'b1;
         end
         head  <= head + {3'b000, num_commit};
         tail  <= tail + {3'b000, num_alloc};
         count <= count + {4'b0000, num_alloc} - {4'b0000, num_commit};
      end
   end

   // NOTE: the payload arrays are deliberately not reset; valid/pending gate every use,
   // and leaving them reset-free keeps them mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (accept0) begin
            wen_mem[alloc0_slot]   <= alloc0_wen;
            waddr_mem[alloc0_slot] <= alloc0_waddr;
         end
         if (accept1) begin
            wen_mem[alloc1_slot]   <= alloc1_wen;
            waddr_mem[alloc1_slot] <= alloc1_waddr;
         end
         // Pipeline A is written last so it wins a same-slot collision.
         if (fill_b_hit) data_mem[fillB_slot] <= fillB_data;
         if (fill_a_hit) data_mem[fillA_slot] <= fillA_data;
      end
   end

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// Scoreboard bench for the reorder buffer: an in-order queue of outstanding ops is
// the reference; directed scenarios are followed by phased random traffic.
module tb_riscv_core_reorder_buffer;

   logic        clk;
   logic        reset;
   logic        alloc0_req, alloc1_req, alloc0_wen, alloc1_wen;
   logic [4:0]  alloc0_waddr, alloc1_waddr, alloc0_slot, alloc1_slot;
   logic        rob_full_stall;
   logic        fillA_val, fillB_val;
   logic [4:0]  fillA_slot, fillB_slot;
   logic [31:0] fillA_data, fillB_data;
   logic        rob_commit_val_1, rob_commit_val_2;
   logic [4:0]  rob_commit_slot_1, rob_commit_slot_2;
   logic        rob_commit_wen_1, rob_commit_wen_2;
   logic [4:0]  rob_commit_waddr_1, rob_commit_waddr_2;
   logic [31:0] rob_commit_data_1, rob_commit_data_2;
   logic [4:0]  rob_rd_slot_0, rob_rd_slot_1;
   logic [31:0] rob_rd_data_0, rob_rd_data_1;

   riscv_core_reorder_buffer dut (
      .clk(clk), .reset(reset),
      .alloc0_req(alloc0_req), .alloc1_req(alloc1_req),
      .alloc0_wen(alloc0_wen), .alloc1_wen(alloc1_wen),
      .alloc0_waddr(alloc0_waddr), .alloc1_waddr(alloc1_waddr),
      .alloc0_slot(alloc0_slot), .alloc1_slot(alloc1_slot),
      .rob_full_stall(rob_full_stall),
      .fillA_val(fillA_val), .fillB_val(fillB_val),
      .fillA_slot(fillA_slot), .fillB_slot(fillB_slot),
      .fillA_data(fillA_data), .fillB_data(fillB_data),
      .rob_commit_val_1(rob_commit_val_1), .rob_commit_val_2(rob_commit_val_2),
      .rob_commit_slot_1(rob_commit_slot_1), .rob_commit_slot_2(rob_commit_slot_2),
      .rob_commit_wen_1(rob_commit_wen_1), .rob_commit_wen_2(rob_commit_wen_2),
      .rob_commit_waddr_1(rob_commit_waddr_1), .rob_commit_waddr_2(rob_commit_waddr_2),
      .rob_commit_data_1(rob_commit_data_1), .rob_commit_data_2(rob_commit_data_2),
      .rob_rd_slot_0(rob_rd_slot_0), .rob_rd_slot_1(rob_rd_slot_1),
      .rob_rd_data_0(rob_rd_data_0), .rob_rd_data_1(rob_rd_data_1)
   );

   typedef struct {
      logic [4:0]  slot;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] data;
      bit          filled;
   } entry_t;

   entry_t      model_q[$];
   logic [4:0]  model_tail;
   int          checks;
   int          failures;
   bit          armed;
   bit          rd0_chk, rd1_chk;
   logic [31:0] rd0_exp, rd1_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is just an in-order list of outstanding ops.
   initial begin
      int         ncommit;
      bit         stall;
      logic [4:0] t;
      entry_t     e;
      model_tail = 5'd0;
      forever begin
         @(posedge clk);
         armed = 1'b1;
         if (reset) begin
            model_q.delete();
            model_tail = 5'd0;
         end else begin
            stall   = model_q.size() > 30;
            ncommit = 0;
            if (model_q.size() > 0 && model_q[0].filled) begin
               ncommit = 1;
               if (model_q.size() > 1 && model_q[1].filled) ncommit = 2;
            end
            for (int i = 0; i < ncommit; i++) void'(model_q.pop_front());
            foreach (model_q[i]) begin
               if (fillB_val && model_q[i].slot == fillB_slot) begin
                  model_q[i].data   = fillB_data;
                  model_q[i].filled = 1'b1;
               end
            end
            foreach (model_q[i]) begin
               if (fillA_val && model_q[i].slot == fillA_slot) begin
                  model_q[i].data   = fillA_data;
                  model_q[i].filled = 1'b1;
               end
            end
            t = model_tail;
            if (!stall && alloc0_req) begin
               e.slot = t; e.wen = alloc0_wen; e.waddr = alloc0_waddr; e.data = '0; e.filled = 1'b0;
               model_q.push_back(e);
               t = t + 5'd1;
            end
            if (!stall && alloc1_req) begin
               e.slot = t; e.wen = alloc1_wen; e.waddr = alloc1_waddr; e.data = '0; e.filled = 1'b0;
               model_q.push_back(e);
               t = t + 5'd1;
            end
            model_tail = t;
         end
      end
   end

   // Monitor: compares every DUT output against the model mid-cycle.
   always @(negedge clk) begin
      bit ev1, ev2;
      if (armed) begin
         ev1 = model_q.size() > 0 && model_q[0].filled;
         ev2 = ev1 && model_q.size() > 1 && model_q[1].filled;
         check("full_stall", {31'd0, rob_full_stall}, {31'd0, model_q.size() > 30});
         check("alloc0_slot", {27'd0, alloc0_slot}, {27'd0, model_tail});
         check("alloc1_slot", {27'd0, alloc1_slot},
               {27'd0, alloc0_req ? model_tail + 5'd1 : model_tail});
         check("commit_val_1", {31'd0, rob_commit_val_1}, {31'd0, ev1});
         check("commit_val_2", {31'd0, rob_commit_val_2}, {31'd0, ev2});
         check("commit_slot_1", {27'd0, rob_commit_slot_1}, ev1 ? {27'd0, model_q[0].slot} : 32'd0);
         check("commit_wen_1", {31'd0, rob_commit_wen_1}, ev1 ? {31'd0, model_q[0].wen} : 32'd0);
         check("commit_waddr_1", {27'd0, rob_commit_waddr_1}, ev1 ? {27'd0, model_q[0].waddr} : 32'd0);
         check("commit_data_1", rob_commit_data_1, ev1 ? model_q[0].data : 32'd0);
         check("commit_slot_2", {27'd0, rob_commit_slot_2}, ev2 ? {27'd0, model_q[1].slot} : 32'd0);
         check("commit_wen_2", {31'd0, rob_commit_wen_2}, ev2 ? {31'd0, model_q[1].wen} : 32'd0);
         check("commit_waddr_2", {27'd0, rob_commit_waddr_2}, ev2 ? {27'd0, model_q[1].waddr} : 32'd0);
         check("commit_data_2", rob_commit_data_2, ev2 ? model_q[1].data : 32'd0);
         if (rd0_chk) check("rd_data_0", rob_rd_data_0, rd0_exp);
         if (rd1_chk) check("rd_data_1", rob_rd_data_1, rd1_exp);
      end
   end

   task automatic idle_inputs();
      alloc0_req = 1'b0; alloc1_req = 1'b0; alloc0_wen = 1'b0; alloc1_wen = 1'b0;
      alloc0_waddr = 5'd0; alloc1_waddr = 5'd0;
      fillA_val = 1'b0; fillB_val = 1'b0; fillA_slot = 5'd0; fillB_slot = 5'd0;
      fillA_data = 32'd0; fillB_data = 32'd0;
      rob_rd_slot_0 = 5'd0; rob_rd_slot_1 = 5'd0;
      rd0_chk = 1'b0; rd1_chk = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic fill(input bit use_a, input logic [4:0] slot, input logic [31:0] data);
      if (use_a) begin
         fillA_val = 1'b1; fillA_slot = slot; fillA_data = data;
      end else begin
         fillB_val = 1'b1; fillB_slot = slot; fillB_data = data;
      end
   endtask

   // Fill the oldest unfilled op from pipeline A; used to drain in directed scenarios.
   task automatic fill_oldest(input logic [31:0] data);
      foreach (model_q[i]) begin
         if (!model_q[i].filled) begin
            fill(1'b1, model_q[i].slot, data);
            break;
         end
      end
   endtask

   task automatic random_cycle(input int alloc_pct, input int fill_pct);
      int unfilled[$];
      int filled[$];
      int k;
      logic [4:0] s;
      bit in_q;
      alloc0_req   = $urandom_range(0, 99) < alloc_pct;
      alloc1_req   = $urandom_range(0, 99) < alloc_pct;
      alloc0_wen   = 1'($urandom);
      alloc1_wen   = 1'($urandom);
      alloc0_waddr = 5'($urandom);
      alloc1_waddr = 5'($urandom);
      foreach (model_q[i]) begin
         if (model_q[i].filled) filled.push_back(i);
         else unfilled.push_back(i);
      end
      if (unfilled.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
         k = unfilled[$urandom_range(0, unfilled.size() - 1)];
         fill(1'b1, model_q[k].slot, $urandom);
      end
      if (unfilled.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
         k = unfilled[$urandom_range(0, unfilled.size() - 1)];
         fill(1'b0, model_q[k].slot, $urandom);
      end
      if (!fillA_val && $urandom_range(0, 99) < 5) begin
         s = 5'($urandom);
         in_q = 1'b0;
         foreach (model_q[i]) if (model_q[i].slot == s) in_q = 1'b1;
         if (!in_q) fill(1'b1, s, 32'hDEAD_0000 | 32'(s));
      end
      if (filled.size() > 0) begin
         k = filled[$urandom_range(0, filled.size() - 1)];
         rob_rd_slot_0 = model_q[k].slot; rd0_exp = model_q[k].data; rd0_chk = 1'b1;
         k = filled[$urandom_range(0, filled.size() - 1)];
         rob_rd_slot_1 = model_q[k].slot; rd1_exp = model_q[k].data; rd1_chk = 1'b1;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      armed    = 1'b0;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Two allocations straight after reset land in slots 0 and 1.
      alloc0_req = 1'b1; alloc0_wen = 1'b1; alloc0_waddr = 5'd3;
      alloc1_req = 1'b1; alloc1_wen = 1'b1; alloc1_waddr = 5'd4;
      next_cycle();
      // Younger op filled first, then older; both commit together afterwards.
      fill(1'b0, 5'd1, 32'h22);
      next_cycle();
      fill(1'b1, 5'd0, 32'h11);
      repeat (3) next_cycle();

      // Out-of-order fill: nothing commits until the older op is filled.
      alloc0_req = 1'b1; alloc1_req = 1'b1; alloc0_waddr = 5'd7; alloc1_waddr = 5'd8;
      next_cycle();
      fill(1'b0, 5'd3, 32'h33);
      repeat (4) next_cycle();
      fill(1'b1, 5'd2, 32'h44);
      repeat (3) next_cycle();

      // Same-slot collision between pipelines.
      alloc0_req = 1'b1; alloc0_wen = 1'b1; alloc0_waddr = 5'd9;
      next_cycle();
      fill(1'b1, 5'd4, 32'hAA);
      fill(1'b0, 5'd4, 32'hBB);
      repeat (3) next_cycle();

      // Fill the buffer, keep requesting while stalled, then drain one op at a time.
      for (int i = 0; i < 20; i++) begin
         alloc0_req = 1'b1; alloc1_req = 1'b1;
         alloc0_waddr = 5'(i); alloc1_waddr = 5'(i + 1);
         next_cycle();
      end
      for (int i = 0; i < 40; i++) begin
         alloc0_req = 1'b1; alloc1_req = (i % 3) == 0;
         fill_oldest(32'h1000 + 32'(i));
         next_cycle();
      end
      for (int i = 0; i < 40; i++) begin
         fill_oldest(32'h2000 + 32'(i));
         next_cycle();
      end

      // Phased random traffic with a reset pulse mid-stream.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         case ((cyc / 500) % 4)
            0: random_cycle(60, 40);
            1: random_cycle(90, 20);
            2: random_cycle(30, 90);
            default: random_cycle(70, 70);
         endcase
         if (cyc == 2222) reset = 1'b1;
         next_cycle();
         reset = 1'b0;
      end
      repeat (3) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_core_reorder_buffer.md
RISCV_CORE_REORDER_BUFFER -- requirements
Module: riscv_core_reorder_buffer

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: alloc0_req, alloc1_req  input  1 each  issue-stage allocation request for ir0/ir1.
REQ-004 SHALL have: alloc0_wen, alloc1_wen  input  1 each  instruction writes the register file.
REQ-005 SHALL have: alloc0_waddr, alloc1_waddr  input  5 each  destination register.
REQ-006 SHALL have: alloc0_slot, alloc1_slot  output  5 each  ROB slot granted to ir0/ir1.
REQ-007 SHALL have: rob_full_stall  output  1  issue must not allocate this cycle.
REQ-008 SHALL have: fillA_val, fillB_val  input  1 each  writeback valid from pipeline A/B.
REQ-009 SHALL have: fillA_slot, fillB_slot  input  5 each; fillA_data, fillB_data  input  32 each.
REQ-010 SHALL have: rob_commit_val_1, rob_commit_val_2  output  1 each  commit valid, oldest first.
REQ-011 SHALL have: rob_commit_slot_1, rob_commit_slot_2  output  5 each  committed slot.
REQ-012 SHALL have: rob_commit_wen_1/_2  output  1; rob_commit_waddr_1/_2  output  5; rob_commit_data_1/_2  output  32.
REQ-013 SHALL have: rob_rd_slot_0, rob_rd_slot_1  input  5; rob_rd_data_0, rob_rd_data_1  output  32  bypass read ports.

Function
REQ-014 SHALL hold 32 entries, each: valid, pending, wen, waddr[4:0], data[31:0]; circular, indexed by 5-bit head (oldest) and tail (next free), plus 6-bit count 0..32.
REQ-015 SHALL drive rob_full_stall = (count > 30), combinational from registered count.
REQ-016 Allocation accepted only when alloc*_req=1 and rob_full_stall=0; requests while stalled SHALL be ignored.
REQ-017 alloc0_slot SHALL equal tail; alloc1_slot SHALL equal tail+1 (mod 32) if alloc0_req else tail; both combinational.
REQ-018 Accepted allocation SHALL set valid=1, pending=1, record wen/waddr at the granted slot next edge; tail advances by number accepted (0..2), wrapping mod 32.
REQ-019 Fill with fill*_val=1 to a valid entry SHALL write data and clear pending next edge; fill to an invalid entry SHALL be ignored.
REQ-020 fillA and fillB to the same slot in one cycle: fillA data SHALL win.
REQ-021 rob_commit_val_1 SHALL = valid[head] && !pending[head]; rob_commit_val_2 SHALL = rob_commit_val_1 && valid[head+1] && !pending[head+1]; combinational from registered state.
REQ-022 Commit outputs slot/wen/waddr/data SHALL reflect entries head and head+1; when val=0, slot/wen/waddr/data SHALL be 0.
REQ-023 On each edge, committed entries SHALL have valid cleared, head advances by commits (0..2) mod 32.
REQ-024 A fill in cycle N SHALL not make an entry committable before cycle N+1 (no fill-to-commit bypass).
REQ-025 count SHALL update as count + accepted_allocs - commits in the same edge; simultaneous alloc and commit permitted, including at count 31/32 and at head/tail wrap.
REQ-026 rob_rd_data_k SHALL = data[rob_rd_slot_k] combinational, regardless of valid/pending.
REQ-027 Allocation to a slot being committed the same edge is impossible by REQ-015 and SHALL not be specially handled.

Reset
REQ-028 On reset: head=0, tail=0, count=0, all valid and pending cleared; data/wen/waddr need not reset.
REQ-029 After reset: rob_full_stall=0, rob_commit_val_1/2=0, alloc0_slot=0, alloc1_slot=0 (with alloc0_req=1: 1).
REQ-030 Reset SHALL override any concurrent alloc, fill or commit in that cycle.

Verification
REQ-031 Reset, alloc0+alloc1 (waddr 3,4, wen=1) -> slots 0,1; next cycle count=2, commit_val_1=0.
REQ-032 Fill B slot1 data 0x22, next cycle fill A slot0 data 0x11 -> cycle after: commit_val_1=1 slot0 waddr3 data 0x11, commit_val_2=1 slot1 data 0x22; then count=0.
REQ-033 Out-of-order fill: only slot1 filled -> commit_val_1=0, commit_val_2=0 until slot0 filled.
REQ-034 Allocate 31 entries -> rob_full_stall=1, further alloc_req ignored; commit one -> stall deasserts the cycle after count falls to 30.
REQ-035 Run 40 alloc/fill/commit pairs -> tail wraps 31->0, commit slots sequence 30,31 then 0,1 in order, no lost entries.
REQ-036 fillA and fillB same slot, data 0xAA/0xBB -> committed data 0xAA; reset mid-stream -> next cycle commit_val_1=0, count=0.
